// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard sequencer for the 5-stage RV32I core.
// Detects load-use and JALR-operand hazards, sequences redirect flushes,
// honours external memory stalls and keeps saturating perf counters.
// Stall/flush outputs are Mealy (state + inputs) and forced low while reset is low.
module hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FLUSH_CYCLES     = 2,
  parameter int CNT_W            = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wb,
  input  logic             ex_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_load,
  input  logic             redirect,
  input  logic             ext_stall,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_JWAIT   = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  // Down-counter must hold LOAD_USE_BUBBLES-1 and FLUSH_CYCLES-1.
  localparam int MAXC = (LOAD_USE_BUBBLES > FLUSH_CYCLES) ? LOAD_USE_BUBBLES : FLUSH_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] LU_INIT = CW'(LOAD_USE_BUBBLES - 1);
  localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] stall_cycles_r, flush_events_r;

  logic [6:0] opc_s;
  logic [4:0] rs1_s, rs2_s;
  logic       use_rs1_s, use_rs2_s;
  logic       load_use_s, jalr_haz_s;
  logic       stall_s, bubble_s, flush_s, flush_acc_s;

  assign opc_s = id_inst[6:0];
  assign rs1_s = id_inst[19:15];
  assign rs2_s = id_inst[24:20];

  // Decode which source registers the ID instruction actually reads.
  always_comb begin
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    case (opc_s)
      7'b0110011: begin use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      7'b0100011: begin use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      7'b1100011: begin use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      7'b0010011: use_rs1_s = 1'b1;
      7'b0000011: use_rs1_s = 1'b1;
      7'b1100111: use_rs1_s = 1'b1;
      default: begin use_rs1_s = 1'b0; use_rs2_s = 1'b0; end
    endcase
  end

  assign load_use_s = id_valid & ex_load & (ex_rd != 5'd0) &
                      ((use_rs1_s & (ex_rd == rs1_s)) | (use_rs2_s & (ex_rd == rs2_s)));
  assign jalr_haz_s = id_valid & (opc_s == 7'b1100111) & (rs1_s != 5'd0) &
                      ((ex_wb & (ex_rd == rs1_s)) | (mem_load & (mem_rd == rs1_s)));

  // Priority sequencer: ext_stall > redirect > state hold > load_use > jalr_haz.
  always_comb begin
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    flush_s     = 1'b0;
    flush_acc_s = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (ext_stall) begin
      stall_s = 1'b1;
    end else if (redirect) begin
      flush_s     = 1'b1;
      bubble_s    = 1'b1;
      flush_acc_s = 1'b1;
      cnt_nxt_s   = FL_INIT;
      state_nxt_s = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (load_use_s) begin
            stall_s     = 1'b1;
            bubble_s    = 1'b1;
            cnt_nxt_s   = LU_INIT;
            state_nxt_s = (LOAD_USE_BUBBLES > 1) ? ST_LDSTALL : ST_RUN;
          end else if (jalr_haz_s) begin
            stall_s     = 1'b1;
            bubble_s    = 1'b1;
            state_nxt_s = ST_JWAIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_LDSTALL: begin
          stall_s   = 1'b1;
          bubble_s  = 1'b1;
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cnt_r <= CNT_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LDSTALL;
          end
        end
        ST_JWAIT: begin
          if (jalr_haz_s) begin
            stall_s     = 1'b1;
            bubble_s    = 1'b1;
            state_nxt_s = ST_JWAIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_s   = 1'b1;
          bubble_s  = 1'b1;
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cnt_r <= CNT_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // State and bubble/flush down-counter.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_events_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cycles_r != SAT)) begin
        stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_acc_s && (flush_events_r != SAT)) begin
        flush_events_r <= flush_events_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Mealy outputs are gated by reset so they drop asynchronously.
  assign stall_if     = stall_s  & reset;
  assign stall_id     = stall_s  & reset;
  assign bubble_ex    = bubble_s & reset;
  assign flush_if     = flush_s  & reset;
  assign state        = state_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_events = flush_events_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// dut uses default parameters; dut_b uses LOAD_USE_BUBBLES=3, CNT_W=2.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] id_inst;
  logic        id_valid, ex_wb, ex_load, mem_load, redirect, ext_stall;
  logic [4:0]  ex_rd, mem_rd;

  logic        stall_if, stall_id, bubble_ex, flush_if;
  logic [1:0]  state;
  logic [15:0] stall_cycles, flush_events;

  logic        b_stall_if, b_stall_id, b_bubble_ex, b_flush_if;
  logic [1:0]  b_state;
  logic [1:0]  b_stall_cycles, b_flush_events;

  int checks = 0;
  int failures = 0;

  logic [3:0] outs, b_outs;
  assign outs   = {stall_if, stall_id, bubble_ex, flush_if};
  assign b_outs = {b_stall_if, b_stall_id, b_bubble_ex, b_flush_if};

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK(CLK), .reset(reset), .id_inst(id_inst), .id_valid(id_valid),
    .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_load(ex_load), .mem_rd(mem_rd),
    .mem_load(mem_load), .redirect(redirect), .ext_stall(ext_stall),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .state(state), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  hazard_ctrl #(.LOAD_USE_BUBBLES(3), .FLUSH_CYCLES(2), .CNT_W(2)) dut_b (
    .CLK(CLK), .reset(reset), .id_inst(id_inst), .id_valid(id_valid),
    .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_load(ex_load), .mem_rd(mem_rd),
    .mem_load(mem_load), .redirect(redirect), .ext_stall(ext_stall),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .bubble_ex(b_bubble_ex),
    .flush_if(b_flush_if), .state(b_state), .stall_cycles(b_stall_cycles),
    .flush_events(b_flush_events)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    id_inst = 32'h0000_0013; id_valid = 1'b0; ex_rd = 5'd0; ex_wb = 1'b0;
    ex_load = 1'b0; mem_rd = 5'd0; mem_load = 1'b0; redirect = 1'b0; ext_stall = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    id_inst = 32'h0072_8333; id_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd5; redirect = 1'b1;
    #1;
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL reset_outs got=%b exp=0000", outs); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({stall_cycles, flush_events} !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events); end
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset(); step();
    id_inst = 32'h0072_8333; id_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd5;
    #1;
    checks++; if (outs !== 4'b1110) begin failures++; $display("FAIL lu_stall got=%b exp=1110", outs); end
    step();
    ex_load = 1'b0;
    #1;
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL lu_release got=%b exp=0000", outs); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL lu_state got=%0d exp=0", state); end
    checks++; if (stall_cycles !== 16'd1) begin failures++; $display("FAIL lu_stall_cycles got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_source_use();
    do_reset(); step();
    // addi x6,x5,7: rs2 field = 7 but not a used source
    id_inst = 32'h0072_8313; id_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd7;
    #1;
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL addi_no_rs2 got=%b exp=0000", outs); end
    // sw x7,0(x5): rs2 = 7 is used
    id_inst = 32'h0072_A023;
    #1;
    checks++; if (outs !== 4'b1110) begin failures++; $display("FAIL sw_rs2 got=%b exp=1110", outs); end
    id_valid = 1'b0;
    #1;
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL id_invalid got=%b exp=0000", outs); end
  endtask

  task automatic test_x0();
    do_reset(); step();
    id_inst = 32'h0000_0333; id_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd0;
    #1;
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL x0_outs got=%b exp=0000", outs); end
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL x0_state got=%0d exp=0", state); end
  endtask

  task automatic test_jalr();
    do_reset(); step();
    id_inst = 32'h0002_80E7; id_valid = 1'b1; ex_wb = 1'b1; ex_rd = 5'd5;
    #1;
    checks++; if (outs !== 4'b1110) begin failures++; $display("FAIL jalr_n got=%b exp=1110", outs); end
    step();
    ex_wb = 1'b0; ex_rd = 5'd0; mem_load = 1'b1; mem_rd = 5'd5;
    #1;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL jalr_state1 got=%0d exp=2", state); end
    checks++; if (outs !== 4'b1110) begin failures++; $display("FAIL jalr_n1 got=%b exp=1110", outs); end
    step();
    mem_load = 1'b0;
    #1;
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL jalr_n2 got=%b exp=0000", outs); end
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL jalr_run got=%0d exp=0", state); end
    checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL jalr_stall_cycles got=%0d exp=2", stall_cycles); end
  endtask

  task automatic test_redirect_cancels();
    do_reset(); step();
    id_inst = 32'h0072_8333; id_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd5;
    #1;
    checks++; if (b_outs !== 4'b1110) begin failures++; $display("FAIL rc_lu got=%b exp=1110", b_outs); end
    step();
    checks++; if (b_state !== 2'd1) begin failures++; $display("FAIL rc_ldstall got=%0d exp=1", b_state); end
    ex_load = 1'b0; redirect = 1'b1;
    #1;
    checks++; if (b_outs !== 4'b0011) begin failures++; $display("FAIL rc_flush1 got=%b exp=0011", b_outs); end
    step();
    redirect = 1'b0;
    #1;
    checks++; if (b_state !== 2'd3) begin failures++; $display("FAIL rc_state_flush got=%0d exp=3", b_state); end
    checks++; if (b_outs !== 4'b0011) begin failures++; $display("FAIL rc_flush2 got=%b exp=0011", b_outs); end
    step();
    checks++; if (b_state !== 2'd0) begin failures++; $display("FAIL rc_run got=%0d exp=0", b_state); end
    checks++; if (b_outs !== 4'b0000) begin failures++; $display("FAIL rc_idle got=%b exp=0000", b_outs); end
    checks++; if (b_flush_events !== 2'd1) begin failures++; $display("FAIL rc_flush_events got=%0d exp=1", b_flush_events); end
    checks++; if (b_stall_cycles !== 2'd1) begin failures++; $display("FAIL rc_stall_cycles got=%0d exp=1", b_stall_cycles); end
  endtask

  task automatic test_ext_stall();
    do_reset(); step();
    redirect = 1'b1;
    #1;
    checks++; if (outs !== 4'b0011) begin failures++; $display("FAIL es_redirect got=%b exp=0011", outs); end
    step();
    redirect = 1'b0; ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs !== 4'b1100) begin failures++; $display("FAIL es_hold%0d got=%b exp=1100", i, outs); end
      checks++; if (state !== 2'd3) begin failures++; $display("FAIL es_frozen%0d got=%0d exp=3", i, state); end
      step();
    end
    ext_stall = 1'b0;
    #1;
    checks++; if (outs !== 4'b0011) begin failures++; $display("FAIL es_flush got=%b exp=0011", outs); end
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL es_run got=%0d exp=0", state); end
    checks++; if (stall_cycles !== 16'd3) begin failures++; $display("FAIL es_stall_cycles got=%0d exp=3", stall_cycles); end
    checks++; if (flush_events !== 16'd1) begin failures++; $display("FAIL es_flush_events got=%0d exp=1", flush_events); end
  endtask

  task automatic test_redirect_during_stall();
    do_reset(); step();
    ext_stall = 1'b1; redirect = 1'b1;
    #1;
    checks++; if (outs !== 4'b1100) begin failures++; $display("FAIL rds_outs got=%b exp=1100", outs); end
    step();
    checks++; if (flush_events !== 16'd0) begin failures++; $display("FAIL rds_events got=%0d exp=0", flush_events); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rds_state got=%0d exp=0", state); end
  endtask

  task automatic test_saturate();
    do_reset(); step();
    ext_stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ext_stall = 1'b0;
    checks++; if (b_stall_cycles !== 2'd3) begin failures++; $display("FAIL sat_stall_b got=%0d exp=3", b_stall_cycles); end
    checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL sat_stall_a got=%0d exp=5", stall_cycles); end
    redirect = 1'b1;
    for (int i = 0; i < 5; i++) step();
    redirect = 1'b0;
    checks++; if (b_flush_events !== 2'd3) begin failures++; $display("FAIL sat_flush_b got=%0d exp=3", b_flush_events); end
    checks++; if (flush_events !== 16'd5) begin failures++; $display("FAIL sat_flush_a got=%0d exp=5", flush_events); end
  endtask

  task automatic test_reset_mid_jwait();
    do_reset(); step();
    id_inst = 32'h0002_80E7; id_valid = 1'b1; ex_wb = 1'b1; ex_rd = 5'd5;
    step();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rm_jwait got=%0d exp=2", state); end
    reset = 1'b0;
    #1;
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL rm_outs got=%b exp=0000", outs); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rm_state got=%0d exp=0", state); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL rm_cnt got=%0d exp=0", stall_cycles); end
    clear_inputs();
    reset = 1'b1;
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rm_after got=%0d exp=0", state); end
    checks++; if (outs !== 4'b0000) begin failures++; $display("FAIL rm_after_outs got=%b exp=0000", outs); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #12;
    test_reset();
    test_load_use();
    test_source_use();
    test_x0();
    test_jalr();
    test_redirect_cancels();
    test_ext_stall();
    test_redirect_during_stall();
    test_saturate();
    test_reset_mid_jwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
